// File: rtl/arb_select_reg.sv
// N:1 arbitrated selector with a single registered output stage and valid/ready on every port.
// Optional packet lock (in_last/out_last) is enabled by defining ARB_SELECT_LOCK_EN.
module arb_select_reg #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned MODE   = 0,
    localparam int unsigned SEL_W = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
`ifdef ARB_SELECT_LOCK_EN
    input  logic [NUM_CH-1:0]       in_last,
    output logic                    out_last,
`endif
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    logic              can_load, accept, adv_ptr;
    logic              srch_any, any_grant;
    logic [SEL_W-1:0]  srch_idx, grant_idx;
    logic [NUM_CH-1:0] grant;
    int unsigned       base, idx;

`ifdef ARB_SELECT_LOCK_EN
    logic              lock_q, lock_d;
    logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
    logic              out_last_q, out_last_d;
`endif

    // Search upward from base with wrap; base is 0 for fixed priority.
    always_comb begin
        srch_any = 1'b0;
        srch_idx = '0;
        base     = (MODE == 1) ? 32'(ptr_q) : 32'd0;
        idx      = 0;
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            idx = (base + j) % NUM_CH;
            if (!srch_any && in_valid[idx]) begin
                srch_any = 1'b1;
                srch_idx = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        any_grant = srch_any;
        grant_idx = srch_idx;
`ifdef ARB_SELECT_LOCK_EN
        if (lock_q) begin
            any_grant = in_valid[lock_ch_q];
            grant_idx = lock_ch_q;
        end
`endif
        grant    = NUM_CH'(any_grant) << grant_idx;
        can_load = !out_valid_q || out_ready;
        accept   = can_load && any_grant;
        in_ready = (rst || !can_load) ? '0 : grant;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        adv_ptr     = accept && (MODE == 1);
`ifdef ARB_SELECT_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        out_last_d  = out_last_q;
        adv_ptr     = adv_ptr && in_last[grant_idx];
        if (accept) begin
            lock_d     = !in_last[grant_idx];
            lock_ch_d  = grant_idx;
            out_last_d = in_last[grant_idx];
        end
`endif
        if (can_load) begin
            out_valid_d = any_grant;
        end
        if (accept) begin
            out_data_d = in_data[32'(grant_idx)*WIDTH +: WIDTH];
            out_ch_d   = grant_idx;
        end
        if (adv_ptr) begin
            ptr_d = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
`ifdef ARB_SELECT_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
`ifdef ARB_SELECT_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
`ifdef ARB_SELECT_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule
